// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
// Contents: arbiter FSM state enum, default core count and bus widths,
// lock-owner width and its "no owner" encoding (owner ids are 0..7, so
// the all-ones code never collides with a real core).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int NUM_CORES_DEF = 4;
    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 16;

    localparam int                 OWNER_W    = 4;
    localparam logic [OWNER_W-1:0] LOCK_NONE  = 4'hF;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports: req (request vector), ptr (first index to consider), mask
// (eligibility), winner (one-hot, first eligible request at or above ptr,
// wrapping to index 0), valid (any eligible request present).
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     winner,
    output logic             valid
);

    logic [N-1:0] elig;
    logic [N-1:0] upper;
    logic [N-1:0] hi;
    logic [N-1:0] base;

    always_comb begin
        elig  = req & mask;
        // Bits at or above the pointer; requests there win over wrapped ones.
        upper = ~((N'(1) << ptr) - N'(1));
        hi    = elig & upper;
        base  = (|hi) ? hi : elig;
        // Isolate the lowest set bit of the chosen half.
        winner = base & (~base + N'(1));
        valid  = |elig;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one synchronous data memory among cores
// Ports: clk, rst_n (synchronous active-low); per-core req/we/addr/wdata inputs
// (core i at slice i); gnt/done one-cycle one-hot pulses and broadcast rdata;
// mem_en/mem_we/mem_addr/mem_wdata towards the memory and mem_rdata back from it
// (valid the cycle after mem_en).
// Build option: MEMARB_LOCK_EN adds the per-core lock input, letting a core keep
// exclusive ownership across consecutive accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
`ifdef MEMARB_LOCK_EN
    input  logic [NUM_CORES-1:0]        lock,
`endif
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PTR_W = $clog2(NUM_CORES);

    arb_state_e state;
    arb_state_e state_nxt;

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_nxt;
    logic [NUM_CORES-1:0] elig_mask;
    logic [NUM_CORES-1:0] pick_oh;
    logic                 pick_valid;
    logic [NUM_CORES-1:0] cur_oh;
    logic                 cur_we;

    logic [PTR_W-1:0]     win_idx;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
`ifdef MEMARB_LOCK_EN
    logic                 sel_lock;
`endif

    rr_pick #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .mask   (elig_mask),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    // One-hot winner to index, and the winner's request fields.
    always_comb begin
        win_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
`ifdef MEMARB_LOCK_EN
        sel_lock  = 1'b0;
`endif
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_oh[i]) begin
                win_idx   = PTR_W'(i);
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
`ifdef MEMARB_LOCK_EN
                sel_lock  = lock[i];
`endif
            end
        end
        ptr_nxt = (win_idx == PTR_W'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
    end

`ifdef MEMARB_LOCK_EN
    logic [OWNER_W-1:0]   lock_owner;
    logic [NUM_CORES-1:0] owner_oh;
    logic                 locked;

    // A lock only bites while its owner is still requesting; once the owner
    // drops req in IDLE every core becomes eligible again in that same cycle.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (lock_owner == OWNER_W'(i)) begin
                owner_oh[i] = 1'b1;
            end
        end
        locked    = |(owner_oh & req);
        elig_mask = locked ? owner_oh : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_owner <= LOCK_NONE;
        end else if (state == ST_IDLE) begin
            if (pick_valid) begin
                lock_owner <= sel_lock ? OWNER_W'(win_idx) : LOCK_NONE;
            end else if (!locked) begin
                lock_owner <= LOCK_NONE;
            end
        end
    end
`else
    assign elig_mask = '1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs: pulses clear every cycle, memory fields hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_oh    <= '0;
            cur_we    <= 1'b0;
        end else begin
            gnt    <= '0;
            done   <= '0;
            mem_en <= 1'b0;
            if (state == ST_IDLE && pick_valid) begin
                gnt       <= pick_oh;
                mem_en    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                cur_oh    <= pick_oh;
                cur_we    <= sel_we;
                ptr       <= ptr_nxt;
            end
            // mem_rdata is valid during WAIT for the access issued two cycles ago.
            if (state == ST_WAIT) begin
                done <= cur_oh;
                if (!cur_we) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*16-1:0] addr;
    logic [N*16-1:0] wdata;
`ifdef MEMARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [15:0]    rdata;
    logic           mem_en;
    logic           mem_we;
    logic [15:0]    mem_addr;
    logic [15:0]    mem_wdata;
    logic [15:0]    mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.NUM_CORES(N), .DATA_W(16), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef MEMARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [15:0] init_val(input int i);
        return (i == 16) ? 16'hBEEF : (16'h5A00 | 16'(i));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Synchronous-read memory attached to the arbiter.
    logic [15:0] tb_mem [256];
    bit tb_mem_ready = 0;
    always @(posedge clk) begin
        if (!tb_mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] = init_val(i);
            tb_mem_ready = 1;
        end else if (mem_en === 1'b1) begin
            if (mem_we) tb_mem[mem_addr[7:0]] = mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[7:0]];
        end
    end

    // Transaction-level reference: an access occupies 3 cycles; the grant is
    // seen the cycle after the deciding edge and done two cycles after that.
    logic [15:0] m_mem [256];
    bit          m_ready = 0;
    int          m_busy = 0;
    int          m_ptr = 0;
    int          m_cur = 0;
    bit          m_cur_we = 0;
    logic [15:0] m_pend;
`ifdef MEMARB_LOCK_EN
    int          m_owner = -1;
`endif
    logic [N-1:0] e_gnt, e_done;
    logic         e_en, e_we;
    logic [15:0]  e_addr, e_wdata, e_rdata;

    always @(posedge clk) begin
        int w;
        if (!m_ready) begin
            for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
            m_ready = 1;
        end
        e_gnt  = '0;
        e_done = '0;
        e_en   = 1'b0;
        if (!rst_n) begin
            e_we = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
            m_busy = 0; m_ptr = 0;
`ifdef MEMARB_LOCK_EN
            m_owner = -1;
`endif
        end else if (m_busy == 0) begin
            w = -1;
`ifdef MEMARB_LOCK_EN
            if (m_owner >= 0 && req[m_owner]) w = m_owner;
`endif
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_en     = 1'b1;
                e_we     = we[w];
                e_addr   = addr[w*16 +: 16];
                e_wdata  = wdata[w*16 +: 16];
                if (we[w]) m_mem[e_addr[7:0]] = e_wdata;
                else       m_pend = m_mem[e_addr[7:0]];
                m_cur    = w;
                m_cur_we = we[w];
                m_ptr    = (w + 1) % N;
                m_busy   = 2;
            end
`ifdef MEMARB_LOCK_EN
            if (w >= 0) m_owner = lock[w] ? w : -1;
            else        m_owner = -1;
`endif
        end else if (m_busy == 2) begin
            m_busy = 1;
        end else begin
            e_done[m_cur] = 1'b1;
            if (!m_cur_we) e_rdata = m_pend;
            m_busy = 0;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en)
            check("cycle", {gnt, done, mem_en, mem_we, mem_addr, mem_wdata, rdata},
                           {e_gnt, e_done, e_en, e_we, e_addr, e_wdata, e_rdata});
    end

    typedef struct {
        int          core;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t tbl[6];

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
`ifdef MEMARB_LOCK_EN
        lock  = '0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_any_gnt(input int budget, output int t);
        t = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                t = i;
                break;
            end
        end
    endtask

    initial begin
        logic [N-1:0] oh;
        int t;

        tbl[0] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[1] = '{3, 1'b1, 16'h00FF, 16'h1234, 16'hBEEF};
        tbl[2] = '{0, 1'b0, 16'h00FF, 16'h0000, 16'h1234};
        tbl[3] = '{2, 1'b1, 16'h0020, 16'hCAFE, 16'h1234};
        tbl[4] = '{2, 1'b0, 16'h0020, 16'h0000, 16'hCAFE};
        tbl[5] = '{0, 1'b0, 16'h0003, 16'h0000, 16'h5A03};

        rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef MEMARB_LOCK_EN
        lock = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", {gnt, done, mem_en, mem_we, mem_addr, mem_wdata, rdata}, 64'd0);
        chk_en = 1;
        rst_n  = 1'b1;

        // Single-requester accesses: grant next cycle, done two cycles later.
        for (int i = 0; i < 6; i++) begin
            oh = '0;
            oh[tbl[i].core] = 1'b1;
            req = oh;
            we[tbl[i].core] = tbl[i].wr;
            addr[tbl[i].core*16 +: 16]  = tbl[i].a;
            wdata[tbl[i].core*16 +: 16] = tbl[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), gnt, oh);
            check($sformatf("vec%0d_mem", i), {mem_en, mem_we, mem_addr, mem_wdata},
                  {1'b1, tbl[i].wr, tbl[i].a, tbl[i].d});
            req = '0;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_done", i), done, oh);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
        end
        repeat (2) @(negedge clk);

        // All four request together: order 0,1,2,3, three cycles apart.
        do_reset();
        we = '0;
        for (int k = 0; k < N; k++) addr[k*16 +: 16] = 16'h0040 + 16'(k);
        req = 4'hF;
        for (int k = 0; k < N; k++) begin
            wait_any_gnt(8, t);
            oh = '0;
            oh[k] = 1'b1;
            check($sformatf("rr4_order%0d", k), gnt, oh);
            check($sformatf("rr4_space%0d", k), t, (k == 0) ? 1 : 3);
            req = req & ~gnt;
        end
        repeat (3) @(negedge clk);

        // Cores 0 and 2 always requesting: strict alternation.
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            wait_any_gnt(8, t);
            check($sformatf("alt_gnt%0d", k), gnt, (k % 2 == 0) ? 4'b0001 : 4'b0100);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Reset while in WAIT aborts the access.
        do_reset();
        addr[16 +: 16] = 16'h0010;
        req = 4'b0010;
        @(negedge clk);
        check("abort_gnt1", gnt, 4'b0010);
        req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_zero", {gnt, done, mem_en, mem_we, mem_addr, mem_wdata, rdata}, 64'd0);
        rst_n = 1'b1;
        addr[32 +: 16] = 16'h0020;
        req = 4'b0100;
        @(negedge clk);
        check("abort_gnt2", gnt, 4'b0100);
        req = '0;
        repeat (3) @(negedge clk);

`ifdef MEMARB_LOCK_EN
        // Locked core 1 keeps the memory ahead of core 2.
        do_reset();
        we = 4'b0010;
        lock = 4'b0010;
        req = 4'b0110;
        wait_any_gnt(8, t);
        check("lock_first", gnt, 4'b0010);
        lock = '0;
        wait_any_gnt(8, t);
        check("lock_second", gnt, 4'b0010);
        req[1] = 1'b0;
        wait_any_gnt(8, t);
        check("lock_core2", gnt, 4'b0100);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        // Random traffic including occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            req   = N'($urandom);
            we    = N'($urandom);
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
`ifdef MEMARB_LOCK_EN
            lock  = N'($urandom);
`endif
            @(negedge clk);
        end
        rst_n = 1'b1;
        req = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
